intpoln_nxt_ste_lgc: RTL and testbench
======================================

Name: intpolN_nxt_ste_lgc

Overview:
- Parametrised next-state/sequencing logic for the order-N polynomial interpolator datapath.
- Counts processed samples against the programmed length `ilen` and walks the coefficient-memory address, issuing one-hot coefficient-load strobes.
- Generates the saturating x^i selector and a registered FIFO-bypass enable.
- Adds three features: a continuous (auto-wrap) mode, a frame-done pulse, and a sticky over-length flag.

Parameters:
- CONFIG_WIDTH, 32, width of `ilen` and of the configuration path.
- N_COEF, 3, number of coefficient registers / load strobes (legal 2..8).
- SEL_WIDTH, $clog2(N_COEF+1), width of `sel_xi` (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous to `clk`, active-high.
- clear  input  1  synchronous soft clear, active-high; same effect as `rst`.
- Empty  input  1  input FIFO empty.
- Afull  input  1  output FIFO almost full.
- busy  input  1  interpolator running.
- en_sum  input  1  one sample accumulated this cycle.
- en_M_addr  input  1  advance coefficient-memory address.
- done  input  1  frame finished; clears sample counter.
- cont_mode  input  1  1 = auto-wrap sample counter at end of frame.
- ilen  input  CONFIG_WIDTH  frame length in samples.
- comp_cnt  output  1  sample counter has reached `ilen`-1.
- comp_addr  output  1  last coefficient load in progress.
- Ld_M  output  N_COEF  one-hot coefficient-load strobes.
- sel_xi  output  SEL_WIDTH  x^i term selector.
- FIFO_bypass  output  1  registered FIFO-bypass enable.
- frame_done  output  1  one-cycle pulse at the last sample of a frame.
- ovf  output  1  sticky: `en_sum` seen beyond frame end in non-continuous mode.

Behaviour:
- Reset/clear:
  - `rst` or `clear` sampled high on a clk edge sets cnt=0, M_cnt=0, FIFO_bypass=0, frame_done=0, ovf=0.
  - Reset has priority over every other input.
  - Reset mid-frame discards all progress; no pulse is emitted.
- Internal registers:
  - cnt is CONFIG_WIDTH+1 bits.
  - M_cnt is $clog2(N_COEF+1) bits, range 0..N_COEF.
- Coefficient address:
  - When `en_M_addr`=1, M_cnt increments. From N_COEF it wraps to 0; otherwise it holds.
  - Ld_M[k] = (M_cnt == k+1), decoded combinationally from the register, so a strobe appears 1 cycle after `en_M_addr`. At most one bit is set; all are 0 when M_cnt=0.
  - comp_addr = Ld_M[N_COEF-1].
  - `done` does not affect M_cnt.
- comp_cnt (combinational):
  - 1 when `ilen`=0.
  - Otherwise 1 iff cnt >= `ilen`-1, compared at CONFIG_WIDTH+1 bits with no underflow.
- Sample counter priority, evaluated each cycle (first match wins):
  - `done`=1: cnt <= 0.
  - `en_sum`=1 and comp_cnt=1 and `cont_mode`=1: cnt <= 0 (wrap).
  - `en_sum`=1 and comp_cnt=1 and `cont_mode`=0: cnt <= cnt+1, saturating at all-ones; ovf <= 1 if cnt > `ilen`-1 (i.e. `en_sum` already past the last sample).
  - `en_sum`=1 otherwise: cnt <= cnt+1.
- frame_done:
  - Registered. Goes to 1 the cycle after an `en_sum` with comp_cnt=1 and cnt == `ilen`-1 (or `ilen`=0 and cnt=0); 0 otherwise.
  - `done` in the same cycle as that `en_sum` still produces the pulse.
- ovf: cleared only by `rst`, `clear` or `done`. `done` clearing beats a simultaneous set.
- sel_xi (combinational): cnt+1 when cnt < N_COEF, else N_COEF. It therefore saturates at N_COEF and never exceeds it.
- FIFO_bypass <= `busy` & ~`Empty` & ~`Afull`, registered with 1-cycle latency and no combinational path.
- `ilen` may change only while `busy`=0; behaviour under a mid-frame change is undefined but must not produce X.

Test Plan:
- Reset + ilen=4, N_COEF=3, cont_mode=0: assert rst 2 cycles, then 6 en_sum pulses → all outputs 0 during reset; comp_cnt rises after the 3rd en_sum; frame_done pulses once, after the 4th; ovf=1 after the 5th; sel_xi sequence 1,2,3,3,3.
- cont_mode=1, ilen=3, 7 consecutive en_sum → cnt 1,2,0,1,2,0,1; frame_done pulses after the 3rd and 6th; ovf stays 0.
- N_COEF=5, en_M_addr held 7 cycles → Ld_M = 00001,00010,00100,01000,10000,00000,00001 (one cycle lag); comp_addr high only on 10000.
- done together with en_sum at cnt=ilen-1 → cnt=0 next cycle, frame_done=1; done with ovf=1 → ovf=0.
- busy=1, toggle Empty/Afull → FIFO_bypass follows (busy & ~Empty & ~Afull) exactly 1 cycle later; a 1-cycle Empty glitch gives a 1-cycle low.
- ilen=0, single en_sum → comp_cnt=1 from reset, frame_done pulse; clear asserted mid-frame at cnt=2 → cnt=0, no frame_done.

Source files
------------

// File: rtl/intpoln_nxt_ste_lgc_if.sv
`default_nettype none
// ============================================================================
// Module      : intpoln_nxt_ste_lgc_if
// Description : Control/status bundle between the interpolator sequencer and
//               its surroundings.
//               master : drives FIFO status, run/accumulate/address strobes,
//                        frame controls and the programmed length.
//               slave  : the sequencer; returns counter/address flags, load
//                        strobes, x^i selector, bypass, frame-done and ovf.
// Revision    : 1.0 - initial release
// ============================================================================
interface intpoln_nxt_ste_lgc_if #(
  parameter int CONFIG_WIDTH = 32,
  parameter int N_COEF       = 3,
  parameter int SEL_WIDTH    = $clog2(N_COEF + 1)
);
  logic                    clear;
  logic                    Empty;
  logic                    Afull;
  logic                    busy;
  logic                    en_sum;
  logic                    en_M_addr;
  logic                    done;
  logic                    cont_mode;
  logic [CONFIG_WIDTH-1:0] ilen;

  logic                    comp_cnt;
  logic                    comp_addr;
  logic [N_COEF-1:0]       Ld_M;
  logic [SEL_WIDTH-1:0]    sel_xi;
  logic                    FIFO_bypass;
  logic                    frame_done;
  logic                    ovf;

  modport master (
    output clear, Empty, Afull, busy, en_sum, en_M_addr, done, cont_mode, ilen,
    input  comp_cnt, comp_addr, Ld_M, sel_xi, FIFO_bypass, frame_done, ovf
  );

  modport slave (
    input  clear, Empty, Afull, busy, en_sum, en_M_addr, done, cont_mode, ilen,
    output comp_cnt, comp_addr, Ld_M, sel_xi, FIFO_bypass, frame_done, ovf
  );
endinterface
`default_nettype wire

// File: rtl/intpoln_nxt_ste_lgc.sv
`default_nettype none
// ============================================================================
// Module      : intpoln_nxt_ste_lgc
// Description : Next-state / sequencing logic for the order-N polynomial
//               interpolator. Counts accumulated samples against ilen,
//               walks the coefficient address producing one-hot load
//               strobes, derives the saturating x^i selector, registers the
//               FIFO-bypass enable, and flags frame end / over-length.
// Ports       : clk  - rising-edge clock
//               rst  - synchronous active-high reset
//               bus  - intpoln_nxt_ste_lgc_if.slave control/status bundle
// Revision    : 1.0 - initial release
// ============================================================================
module intpoln_nxt_ste_lgc #(
  parameter int CONFIG_WIDTH = 32,
  parameter int N_COEF       = 3,
  parameter int SEL_WIDTH    = $clog2(N_COEF + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  intpoln_nxt_ste_lgc_if.slave bus
);

  localparam logic [CONFIG_WIDTH:0]  c_CNT_ONE = (CONFIG_WIDTH+1)'(1);
  localparam logic [CONFIG_WIDTH:0]  c_CNT_N   = (CONFIG_WIDTH+1)'(N_COEF);
  localparam logic [SEL_WIDTH-1:0]   c_M_ONE   = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0]   c_M_N     = SEL_WIDTH'(N_COEF);

  logic [CONFIG_WIDTH:0]  r_cnt;
  logic [SEL_WIDTH-1:0]   r_m_cnt;
  logic                   r_fifo_bypass;
  logic                   r_frame_done;
  logic                   r_ovf;

  logic [CONFIG_WIDTH:0]  w_ilen_ext;
  logic [CONFIG_WIDTH:0]  w_last;
  logic                   w_ilen_zero;
  logic                   w_comp_cnt;
  logic                   w_at_last;
  logic                   w_past_last;
  logic                   w_cnt_max;

  // Index of the last sample of a frame. A zero length is treated as a
  // one-sample frame so the subtraction never underflows.
  assign w_ilen_ext  = {1'b0, bus.ilen};
  assign w_ilen_zero = (bus.ilen == '0);
  assign w_last      = w_ilen_zero ? '0 : (w_ilen_ext - c_CNT_ONE);
  assign w_comp_cnt  = w_ilen_zero | (r_cnt >= w_last);
  assign w_at_last   = (r_cnt == w_last);
  assign w_past_last = (r_cnt > w_last);
  assign w_cnt_max   = &r_cnt;

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      r_cnt         <= '0;
      r_m_cnt       <= '0;
      r_fifo_bypass <= 1'b0;
      r_frame_done  <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      r_fifo_bypass <= bus.busy & ~bus.Empty & ~bus.Afull;
      // Pulse is independent of done, so a frame closed by done on its
      // last sample still reports completion.
      r_frame_done  <= bus.en_sum & w_comp_cnt & w_at_last;

      if (bus.en_M_addr) begin
        r_m_cnt <= (r_m_cnt == c_M_N) ? '0 : (r_m_cnt + c_M_ONE);
      end

      if (bus.done) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (bus.en_sum) begin
        if (w_comp_cnt && bus.cont_mode) begin
          r_cnt <= '0;
        end else if (w_comp_cnt) begin
          if (!w_cnt_max) begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
          if (w_past_last) begin
            r_ovf <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end
    end
  end

  // Strobe k fires while the address register holds k+1; address 0 is idle.
  generate
    for (genvar k = 0; k < N_COEF; k++) begin : g_ld
      assign bus.Ld_M[k] = (r_m_cnt == SEL_WIDTH'(k + 1));
    end
  endgenerate

  assign bus.comp_addr   = bus.Ld_M[N_COEF-1];
  assign bus.comp_cnt    = w_comp_cnt;
  assign bus.sel_xi      = (r_cnt < c_CNT_N) ? SEL_WIDTH'(r_cnt + c_CNT_ONE) : c_M_N;
  assign bus.FIFO_bypass = r_fifo_bypass;
  assign bus.frame_done  = r_frame_done;
  assign bus.ovf         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_intpoln_nxt_ste_lgc.sv
`default_nettype none
// ============================================================================
// Module      : tb_intpoln_nxt_ste_lgc
// Description : Self-checking bench. Two sequencers (32-bit/3 coefficients
//               and 4-bit/5 coefficients) share one stimulus stream and are
//               checked every cycle against a sample-index model, plus
//               directed scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intpoln_nxt_ste_lgc;

  logic clk = 1'b0;
  logic rst, clear, empty, afull, busy, en_sum, en_m, done, cont;
  logic [31:0] ilen_d;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  intpoln_nxt_ste_lgc_if #(.CONFIG_WIDTH(32), .N_COEF(3)) ia ();
  intpoln_nxt_ste_lgc_if #(.CONFIG_WIDTH(4),  .N_COEF(5)) ib ();

  assign ia.clear = clear;  assign ib.clear = clear;
  assign ia.Empty = empty;  assign ib.Empty = empty;
  assign ia.Afull = afull;  assign ib.Afull = afull;
  assign ia.busy = busy;    assign ib.busy = busy;
  assign ia.en_sum = en_sum; assign ib.en_sum = en_sum;
  assign ia.en_M_addr = en_m; assign ib.en_M_addr = en_m;
  assign ia.done = done;    assign ib.done = done;
  assign ia.cont_mode = cont; assign ib.cont_mode = cont;
  assign ia.ilen = ilen_d;  assign ib.ilen = ilen_d[3:0];

  intpoln_nxt_ste_lgc #(.CONFIG_WIDTH(32), .N_COEF(3)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  intpoln_nxt_ste_lgc #(.CONFIG_WIDTH(4),  .N_COEF(5)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  // ---------------- behavioural model ----------------
  // Sample index within the frame, coefficient address position, and the
  // three registered flags, per instance.
  int     n_of [2] = '{3, 5};
  longint maxc [2] = '{64'h1_FFFF_FFFF, 64'd31};
  longint m_cnt [2];
  int     m_addr [2];
  bit     m_fd [2], m_ovf [2], m_byp [2];

  always @(posedge clk) begin
    longint last;
    last = (ilen_d == 0) ? 0 : longint'(ilen_d) - 1;
    for (int j = 0; j < 2; j++) begin
      if (rst || clear) begin
        m_cnt[j] = 0; m_addr[j] = 0; m_fd[j] = 0; m_ovf[j] = 0; m_byp[j] = 0;
      end else begin
        m_byp[j] = busy && !empty && !afull;
        m_fd[j]  = en_sum && (m_cnt[j] == last);
        if (en_m) m_addr[j] = (m_addr[j] + 1) % (n_of[j] + 1);
        if (done) begin
          m_cnt[j] = 0; m_ovf[j] = 0;
        end else if (en_sum) begin
          if (m_cnt[j] >= last && cont) m_cnt[j] = 0;
          else begin
            if (m_cnt[j] > last) m_ovf[j] = 1;
            if (m_cnt[j] < maxc[j]) m_cnt[j] = m_cnt[j] + 1;
          end
        end
      end
    end
  end

  // Packed view: {comp_cnt, comp_addr, Ld_M[7:0], sel_xi[2:0], byp, fd, ovf}
  function automatic logic [15:0] model_vec(int j);
    longint last;
    logic [7:0] ld;
    int sel;
    last = (ilen_d == 0) ? 0 : longint'(ilen_d) - 1;
    ld   = (m_addr[j] == 0) ? 8'h00 : 8'(1 << (m_addr[j] - 1));
    sel  = (m_cnt[j] < n_of[j]) ? int'(m_cnt[j]) + 1 : n_of[j];
    return {m_cnt[j] >= last, m_addr[j] == n_of[j], ld, 3'(sel),
            m_byp[j], m_fd[j], m_ovf[j]};
  endfunction

  function automatic logic [15:0] dut_vec(int j);
    if (j == 0)
      return {ia.comp_cnt, ia.comp_addr, 5'b0, ia.Ld_M, 1'b0, ia.sel_xi,
              ia.FIFO_bypass, ia.frame_done, ia.ovf};
    return {ib.comp_cnt, ib.comp_addr, 3'b0, ib.Ld_M, ib.sel_xi,
            ib.FIFO_bypass, ib.frame_done, ib.ovf};
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      for (int j = 0; j < 2; j++) begin
        logic [15:0] a, e;
        a = dut_vec(j);
        e = model_vec(j);
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL model_cmp dut%0d t=%0t: got cc=%b ca=%b ld=%b sel=%0d byp=%b fd=%b ovf=%b, expected cc=%b ca=%b ld=%b sel=%0d byp=%b fd=%b ovf=%b",
                   j, $time, a[15], a[14], a[13:6], a[5:3], a[2], a[1], a[0],
                   e[15], e[14], e[13:6], e[5:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int e_sel1 [6] = '{1, 2, 3, 3, 3, 3};
  int e_cc1  [6] = '{0, 0, 1, 1, 1, 1};
  int e_fd1  [6] = '{0, 0, 0, 1, 0, 0};
  int e_ov1  [6] = '{0, 0, 0, 0, 1, 1};
  int e_sel2 [7] = '{2, 3, 1, 2, 3, 1, 2};
  int e_fd2  [7] = '{0, 0, 1, 0, 0, 1, 0};
  int e_ld3  [7] = '{1, 2, 4, 8, 16, 0, 1};
  int e_emp  [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
  int e_afl  [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
  int e_byp  [8] = '{1, 1, 0, 1, 0, 0, 0, 1};

  initial begin
    int prev;
    rst = 1; clear = 0; empty = 0; afull = 0; busy = 0;
    en_sum = 0; en_m = 0; done = 0; cont = 0; ilen_d = 4;

    // Reset for two cycles
    tick(); chk_on = 1'b1;
    tick();
    lit("rst_comp_cnt", 32'(ia.comp_cnt), 0);
    lit("rst_ld_m", 32'(ia.Ld_M), 0);
    lit("rst_frame_done", 32'(ia.frame_done), 0);
    lit("rst_ovf", 32'(ia.ovf), 0);
    lit("rst_bypass", 32'(ia.FIFO_bypass), 0);
    rst = 0;

    // ilen=4, non-continuous, six samples
    for (int k = 0; k < 6; k++) begin
      lit("t1_sel_xi", 32'(ia.sel_xi), 32'(e_sel1[k]));
      en_sum = 1;
      tick();
      lit("t1_comp_cnt", 32'(ia.comp_cnt), 32'(e_cc1[k]));
      lit("t1_frame_done", 32'(ia.frame_done), 32'(e_fd1[k]));
      lit("t1_ovf", 32'(ia.ovf), 32'(e_ov1[k]));
    end
    en_sum = 0;

    // Continuous mode, ilen=3, seven samples
    done = 1; tick(); done = 0;
    lit("t2_ovf_cleared", 32'(ia.ovf), 0);
    cont = 1; ilen_d = 3;
    for (int k = 0; k < 7; k++) begin
      en_sum = 1;
      tick();
      lit("t2_sel_xi_b", 32'(ib.sel_xi), 32'(e_sel2[k]));
      lit("t2_frame_done", 32'(ia.frame_done), 32'(e_fd2[k]));
      lit("t2_ovf", 32'(ia.ovf), 0);
    end
    en_sum = 0; cont = 0;

    // Coefficient address walk on the 5-coefficient instance
    en_m = 1;
    for (int k = 0; k < 7; k++) begin
      tick();
      lit("t3_ld_m", 32'(ib.Ld_M), 32'(e_ld3[k]));
      lit("t3_comp_addr", 32'(ib.comp_addr), (k == 4) ? 32'd1 : 32'd0);
    end
    en_m = 0;

    // done coinciding with the last sample, then done clearing ovf
    ilen_d = 4;
    done = 1; tick(); done = 0;
    en_sum = 1;
    repeat (3) tick();
    done = 1;
    tick();
    done = 0;
    lit("t4_cnt_zero", 32'(ib.sel_xi), 1);
    lit("t4_frame_done", 32'(ia.frame_done), 1);
    repeat (5) tick();
    en_sum = 0;
    lit("t4_ovf_set", 32'(ia.ovf), 1);
    done = 1; tick(); done = 0;
    lit("t4_ovf_cleared", 32'(ia.ovf), 0);

    // FIFO bypass: registered, one-cycle latency, no combinational path
    busy = 1; prev = 0;
    for (int k = 0; k < 8; k++) begin
      empty = e_emp[k][0]; afull = e_afl[k][0];
      #1;
      lit("t5_bypass_nocomb", 32'(ia.FIFO_bypass), 32'(prev));
      tick();
      lit("t5_bypass", 32'(ia.FIFO_bypass), 32'(e_byp[k]));
      prev = e_byp[k];
    end
    busy = 0; empty = 0; afull = 0;

    // ilen=0, then clear mid-frame on what would be the last sample
    ilen_d = 0;
    rst = 1; tick(); rst = 0;
    lit("t6_comp_cnt_len0", 32'(ia.comp_cnt), 1);
    en_sum = 1; tick(); en_sum = 0;
    lit("t6_frame_done_len0", 32'(ia.frame_done), 1);
    ilen_d = 3;
    done = 1; tick(); done = 0;
    en_sum = 1;
    repeat (2) tick();
    clear = 1;
    tick();
    clear = 0; en_sum = 0;
    lit("t6_clear_no_fd", 32'(ia.frame_done), 0);
    lit("t6_clear_cnt", 32'(ib.sel_xi), 1);

    // Counter saturation on the 4-bit instance (5-bit counter)
    ilen_d = 2;
    done = 1; tick(); done = 0;
    en_sum = 1;
    repeat (40) tick();
    en_sum = 0;
    lit("t7_sat_comp_cnt", 32'(ib.comp_cnt), 1);
    lit("t7_sat_ovf", 32'(ib.ovf), 1);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 299) == 0);
      clear  = ($urandom_range(0, 149) == 0);
      done   = (c % 1000 < 700) ? ($urandom_range(0, 39) == 0) : 1'b0;
      en_sum = ($urandom_range(0, 3) != 0);
      en_m   = $urandom_range(0, 1);
      empty  = ($urandom_range(0, 3) == 0);
      afull  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) cont = ~cont;
      if ($urandom_range(0, 19) == 0) busy = ~busy;
      if (!busy && $urandom_range(0, 4) == 0) ilen_d = $urandom_range(0, 10);
      tick();
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
